// File: rtl/seq_array_multiplier.sv
// Shift-add multiplier: WIDTH cycles from accept to out_valid, min issue interval WIDTH+2; result held in DONE until out_ready.
// Optional SIGNED_MODE_EN adds a signed_mode input selecting two's-complement operands (sign-magnitude internally).
module seq_array_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
`ifdef SIGNED_MODE_EN
   ,
   input  logic                 signed_mode
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      count;

   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] acc_final;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   // One iteration: conditional add into the upper half, then shift {carry, acc} right.
   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
      acc_step = {sum, acc[WIDTH-1:1]};
   end

`ifdef SIGNED_MODE_EN
   logic sign;
   logic sign_in;

   // Most-negative operand maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
   always_comb begin
      a_mag   = a;
      b_mag   = b;
      sign_in = 1'b0;
      if (signed_mode) begin
         a_mag   = a[WIDTH-1] ? (~a + 1'b1) : a;
         b_mag   = b[WIDTH-1] ? (~b + 1'b1) : b;
         sign_in = a[WIDTH-1] ^ b[WIDTH-1];
      end
   end

   assign acc_final = sign ? (~acc_step + 1'b1) : acc_step;
`else
   assign a_mag     = a;
   assign b_mag     = b;
   assign acc_final = acc_step;
`endif

   assign product = acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         count     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
`ifdef SIGNED_MODE_EN
         sign      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand    <= a_mag;
                  mplier   <= b_mag;
                  acc      <= '0;
                  count    <= '0;
`ifdef SIGNED_MODE_EN
                  sign     <= sign_in;
`endif
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
               if (count == LAST) begin
                  acc       <= acc_final;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  acc <= acc_step;
               end
            end
            DONE: begin
               // in_ready stays low here so an output handshake never overlaps a new accept.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed bench for seq_array_multiplier: WIDTH=4 instance for function/handshake, WIDTH=8 instance for the wide corner.
module tb_seq_array_multiplier;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, out_valid, out_ready, busy;
   logic [3:0] a, b;
   logic [7:0] product;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] product8;

`ifdef SIGNED_MODE_EN
   logic signed_mode;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seq_array_multiplier #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
`ifdef SIGNED_MODE_EN
      ,
      .signed_mode (signed_mode)
`endif
   );

   seq_array_multiplier #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .product   (product8),
      .busy      (busy8)
`ifdef SIGNED_MODE_EN
      ,
      .signed_mode (1'b0)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [3:0] av, input logic [3:0] bv);
      @(negedge clk);
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Counts edges after the accept edge until out_valid is seen, bounded.
   task automatic wait_done(input string tag, input logic [7:0] exp, input bit toggle);
      int cyc = 0;
      while (cyc < 40) begin
         @(posedge clk);
         cyc++;
         #1;
         if (toggle) begin
            a        = 4'd1;
            b        = 4'd1;
            in_valid = (cyc < 3) ? ~in_valid : 1'b0;
         end
         @(negedge clk);
         if (out_valid) break;
      end
      check({tag, " latency"}, cyc, 4);
      check({tag, " product"}, product, exp);
      check({tag, " in_ready in DONE"}, in_ready, 0);
      check({tag, " busy in DONE"}, busy, 1);
   endtask

   task automatic finish_op(input string tag, input logic [7:0] exp);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check({tag, " out_valid after handshake"}, out_valid, 0);
      check({tag, " in_ready after handshake"}, in_ready, 1);
      check({tag, " busy after handshake"}, busy, 0);
      check({tag, " product kept"}, product, exp);
   endtask

   initial begin
      int cyc8;
      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      a          = '0;
      b          = '0;
      in_valid8  = 1'b0;
      out_ready8 = 1'b1;
      a8         = '0;
      b8         = '0;
`ifdef SIGNED_MODE_EN
      signed_mode = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("reset product", product, 0);
      check("reset out_valid", out_valid, 0);
      check("reset busy", busy, 0);
      check("reset in_ready", in_ready, 1);
      rst = 1'b0;

      start_op(4'd13, 4'd11);
      wait_done("13x11", 8'h8F, 1'b0);
      finish_op("13x11", 8'h8F);

      start_op(4'd15, 4'd15);
      wait_done("15x15", 8'hE1, 1'b0);
      finish_op("15x15", 8'hE1);

      start_op(4'd0, 4'd9);
      wait_done("0x9", 8'h00, 1'b0);
      finish_op("0x9", 8'h00);

      start_op(4'd7, 4'd6);
      wait_done("7x6", 8'h2A, 1'b0);
      repeat (6) begin
         @(negedge clk);
         check("hold out_valid", out_valid, 1);
         check("hold product", product, 8'h2A);
         check("hold in_ready", in_ready, 0);
      end
      finish_op("7x6", 8'h2A);

      start_op(4'd5, 4'd5);
      wait_done("5x5 ignore in_valid", 8'h19, 1'b1);
      finish_op("5x5", 8'h19);

      start_op(4'd9, 4'd9);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrun rst out_valid", out_valid, 0);
      check("midrun rst busy", busy, 0);
      check("midrun rst in_ready", in_ready, 1);
      check("midrun rst product", product, 0);
      @(negedge clk);
      rst = 1'b0;
      start_op(4'd3, 4'd4);
      wait_done("3x4 after rst", 8'h0C, 1'b0);
      finish_op("3x4", 8'h0C);

      start_op(4'd2, 4'd3);
      wait_done("2x3", 8'h06, 1'b0);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a         = 4'd4;
      b         = 4'd4;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check("overlap no accept in_ready", in_ready, 1);
      check("overlap no accept busy", busy, 0);
      check("overlap out_valid", out_valid, 0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_done("4x4 after overlap", 8'h10, 1'b0);
      finish_op("4x4", 8'h10);

`ifdef SIGNED_MODE_EN
      signed_mode = 1'b1;
      start_op(4'h8, 4'h8);
      wait_done("signed -8x-8", 8'h40, 1'b0);
      finish_op("signed -8x-8", 8'h40);
      start_op(4'hD, 4'h5);
      wait_done("signed -3x5", 8'hF1, 1'b0);
      finish_op("signed -3x5", 8'hF1);
      signed_mode = 1'b0;
      start_op(4'hD, 4'h5);
      wait_done("unsigned 13x5", 8'h41, 1'b0);
      finish_op("unsigned 13x5", 8'h41);
`endif

      @(negedge clk);
      a8        = 8'd255;
      b8        = 8'd255;
      in_valid8 = 1'b1;
      @(posedge clk);
      #1 in_valid8 = 1'b0;
      cyc8 = 0;
      while (cyc8 < 60) begin
         @(posedge clk);
         cyc8++;
         @(negedge clk);
         if (out_valid8) break;
      end
      check("w8 latency", cyc8, 8);
      check("w8 product", product8, 16'hFE01);
      @(negedge clk);
      check("w8 out_valid after handshake", out_valid8, 0);
      check("w8 in_ready after handshake", in_ready8, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
